// File: rtl/mac_mem_arbiter_pkg.sv
// mac_mem_arbiter_pkg
//   Shared definitions for the L_mac / scratch-memory arbiter:
//   FSM state encoding, default watchdog limit, shared-bus widths and a
//   small wrap-around index helper used for the round-robin pointer.
package mac_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int WD_LIMIT_DEFAULT = 1023;

  localparam int MEM_AW   = 11;  // scratch-memory write address width
  localparam int MEM_DW   = 32;  // scratch-memory write data width
  localparam int MAC_OPW  = 16;  // L_mac operand width (A, B)
  localparam int MAC_ACCW = 32;  // L_mac accumulator width (C)
  localparam int WD_CW    = 11;  // watchdog counter width

  // (idx + 1) mod n without a divider.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mac_mem_arbiter_rr_pick.sv
// mac_mem_arbiter_rr_pick
//   Combinational round-robin picker. Scans the eligible vector starting at
//   i_ptr and wrapping upward; the first set bit wins.
// Ports:
//   i_eligible [N-1:0]  candidate requesters
//   i_ptr      [PW-1:0] index where the search starts
//   o_onehot   [N-1:0]  one-hot winner (zero when nothing is eligible)
//   o_idx      [PW-1:0] winner index (zero when nothing is eligible)
//   o_any               at least one requester is eligible
module mac_mem_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    // Walk from the farthest position back to i_ptr so the candidate closest
    // to the pointer is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (i_eligible[(int'(i_ptr) + k) % N]) begin
        o_onehot                          = '0;
        o_onehot[(int'(i_ptr) + k) % N]   = 1'b1;
        o_idx                             = PW'((int'(i_ptr) + k) % N);
        o_any                             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_mem_arbiter.sv
// mac_mem_arbiter
//   Round-robin owner arbiter for one shared L_mac unit and one shared
//   scratch-memory write port. A requester holds req for its whole
//   transaction; the registered grant selects whose drive signals reach the
//   shared outputs. Every handover costs exactly one dead (ARB_RELEASE) cycle.
//   Optional feature macro: ARB_WATCHDOG_EN (per-grant watchdog revoke).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req[N_REQ]                      ownership requests
//   reqMemWriteEn/Addr/Out          per-requester memory write drive
//   reqL_macOutA/B/C                per-requester L_mac drive
//   grant[N_REQ]                    registered one-hot owner (or zero)
//   busy                            high while in ARB_GRANT
//   memWriteEn/Addr, memOut         shared memory write port
//   L_macOutA/B/C                   shared L_mac inputs
//   wdFault                         one-cycle pulse on watchdog revoke
//   o_dbg_state                     current FSM state
//
// Handshake: req is a level held by the requester for the whole
// transaction; ownership starts the cycle grant[i]=1 is seen and ends when
// the requester drops req. The owner's drive signals reach the shared
// outputs combinationally in every cycle its grant bit is high; with grant=0
// every shared output is 0.
module mac_mem_arbiter
  import mac_mem_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            reqMemWriteEn,
  input  logic [MEM_AW*N_REQ-1:0]     reqMemWriteAddr,
  input  logic [MEM_DW*N_REQ-1:0]     reqMemOut,
  input  logic [MAC_OPW*N_REQ-1:0]    reqL_macOutA,
  input  logic [MAC_OPW*N_REQ-1:0]    reqL_macOutB,
  input  logic [MAC_ACCW*N_REQ-1:0]   reqL_macOutC,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic                        memWriteEn,
  output logic [MEM_AW-1:0]           memWriteAddr,
  output logic [MEM_DW-1:0]           memOut,
  output logic [MAC_OPW-1:0]          L_macOutA,
  output logic [MAC_OPW-1:0]          L_macOutB,
  output logic [MAC_ACCW-1:0]         L_macOutC,
  output logic                        wdFault,
  output arb_state_t                  o_dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       r_state, w_next_state;
  logic [N_REQ-1:0] r_grant, w_grant_next;
  logic [PW-1:0]    r_owner, w_owner_next;
  logic [PW-1:0]    r_ptr, w_ptr_next;
  logic [N_REQ-1:0] w_eligible, w_mask, w_pick_oh;
  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_owner_req;
  logic             w_revoke;

  assign w_owner_req = req[r_owner];
  assign w_eligible  = req & ~w_mask;

  mac_mem_arbiter_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_onehot   (w_pick_oh),
    .o_idx      (w_pick_idx),
    .o_any      (w_pick_any)
  );

`ifdef ARB_WATCHDOG_EN
  logic [WD_CW-1:0] r_wd_cnt;
  logic [N_REQ-1:0] r_mask;
  logic             r_wd_fault;

  // Counter is 0 on the first ARB_GRANT cycle, so the revoke fires after the
  // owner has held the resources for WD_LIMIT cycles.
  assign w_revoke = (r_state == ARB_GRANT) && w_owner_req &&
                    (r_wd_cnt == WD_CW'(WD_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt   <= '0;
      r_mask     <= '0;
      r_wd_fault <= 1'b0;
    end else begin
      r_wd_fault <= w_revoke;
      r_wd_cnt   <= (r_state == ARB_GRANT && !w_revoke) ? r_wd_cnt + 1'b1 : '0;
      // A masked requester becomes eligible again only after it drops req.
      r_mask     <= (r_mask & req) | (w_revoke ? r_grant : '0);
    end
  end

  assign w_mask  = r_mask;
  assign wdFault = r_wd_fault;
`else
  logic w_unused_wd_limit;
  assign w_unused_wd_limit = (WD_LIMIT != 0);
  assign w_revoke = 1'b0;
  assign w_mask   = '0;
  assign wdFault  = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_grant_next = r_grant;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    case (r_state)
      ARB_IDLE, ARB_RELEASE: begin
        if (w_pick_any) begin
          w_next_state = ARB_GRANT;
          w_grant_next = w_pick_oh;
          w_owner_next = w_pick_idx;
        end else begin
          w_next_state = ARB_IDLE;
          w_grant_next = '0;
        end
      end
      ARB_GRANT: begin
        if (!w_owner_req || w_revoke) begin
          w_next_state = ARB_RELEASE;
          w_grant_next = '0;
          w_ptr_next   = PW'(next_idx(int'(r_owner), N_REQ));
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_grant_next;
      r_owner <= w_owner_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // AND-OR mux on the registered one-hot grant; zero grant gives zero outputs.
  always_comb begin
    memWriteEn   = 1'b0;
    memWriteAddr = '0;
    memOut       = '0;
    L_macOutA    = '0;
    L_macOutB    = '0;
    L_macOutC    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        memWriteEn   = memWriteEn   | reqMemWriteEn[i];
        memWriteAddr = memWriteAddr | reqMemWriteAddr[i*MEM_AW +: MEM_AW];
        memOut       = memOut       | reqMemOut[i*MEM_DW +: MEM_DW];
        L_macOutA    = L_macOutA    | reqL_macOutA[i*MAC_OPW +: MAC_OPW];
        L_macOutB    = L_macOutB    | reqL_macOutB[i*MAC_OPW +: MAC_OPW];
        L_macOutC    = L_macOutC    | reqL_macOutC[i*MAC_ACCW +: MAC_ACCW];
      end
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state == ARB_GRANT);
  assign o_dbg_state = r_state;

endmodule
